// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the instruction sequencer and the CPU datapath.
// The sequencer (master) drives every control strobe; the datapath (slave) returns IR and CON.
interface ctrl_sequencer_if;
  localparam int unsigned IR_W  = 32;
  localparam int unsigned RX_W  = 16;
  localparam int unsigned ALU_W = 5;

  logic [IR_W-1:0]  IR_Data;
  logic             CON_out;

  logic             PC_out;
  logic             Zhigh_out;
  logic             Zlow_out;
  logic             MDR_out;
  logic             C_out;

  logic             PC_in;
  logic             IR_in;
  logic             Y_in;
  logic             Z_in;
  logic             MAR_in;
  logic             MDR_in;
  logic             IncPC;
  logic             CON_in;

  logic             Read;

  logic             Gra;
  logic             Grb;
  logic             Grc;
  logic             Rin;
  logic             Rout;

  logic [RX_W-1:0]  RX_in_man;
  logic [ALU_W-1:0] alu_instruction_bits;
  logic             run;

  modport master (
    input  IR_Data, CON_out,
    output PC_out, Zhigh_out, Zlow_out, MDR_out, C_out,
    output PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC, CON_in,
    output Read, Gra, Grb, Grc, Rin, Rout,
    output RX_in_man, alu_instruction_bits, run
  );

  modport slave (
    output IR_Data, CON_out,
    input  PC_out, Zhigh_out, Zlow_out, MDR_out, C_out,
    input  PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, IncPC, CON_in,
    input  Read, Gra, Grb, Grc, Rin, Rout,
    input  RX_in_man, alu_instruction_bits, run
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Moore control sequencer: fetch (T0-T2), then opcode-dependent execute (T3-T6).
// Outputs decode from the state register; the T3 opcode is captured so later steps ignore IR changes.
module ctrl_sequencer (
  input  logic             clk,
  input  logic             clr,
  ctrl_sequencer_if.master bus
);
  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_RFIRST = OP_W'(3);
  localparam logic [OP_W-1:0] OP_RLAST  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BR     = OP_W'(19);
  localparam logic [OP_W-1:0] OP_JR     = OP_W'(20);
  localparam logic [OP_W-1:0] OP_JAL    = OP_W'(21);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'(27);
  localparam logic [OP_W-1:0] ALU_ADD   = OP_W'(3);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] op_live;
  logic            unused_ir;

  assign op_live   = bus.IR_Data[31:27];
  assign unused_ir = ^bus.IR_Data[26:0];

  function automatic logic is_rtype(input logic [OP_W-1:0] op);
    return (op >= OP_RFIRST) && (op <= OP_RLAST);
  endfunction

  // State register and next-state; opcode is frozen at T3 for the remaining execute steps.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_RST;
      op_q  <= '0;
    end else begin
      case (state)
        S_RST: state <= S_T0;
        S_T0:  state <= S_T1;
        S_T1:  state <= S_T2;
        S_T2:  state <= S_T3;
        S_T3: begin
          op_q <= op_live;
          if (is_rtype(op_live) || op_live == OP_JAL || op_live == OP_BR)
            state <= S_T4;
          else if (op_live == OP_HALT)
            state <= S_HALT;
          else
            state <= S_T0;
        end
        S_T4:  state <= (is_rtype(op_q) || op_q == OP_BR) ? S_T5 : S_T0;
        S_T5:  state <= (op_q == OP_BR) ? S_T6 : S_T0;
        S_T6:  state <= S_T0;
        S_HALT: state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  // Control decode; anything not set for a state stays low.
  always_comb begin
    bus.PC_out               = 1'b0;
    bus.Zhigh_out            = 1'b0;
    bus.Zlow_out             = 1'b0;
    bus.MDR_out              = 1'b0;
    bus.C_out                = 1'b0;
    bus.PC_in                = 1'b0;
    bus.IR_in                = 1'b0;
    bus.Y_in                 = 1'b0;
    bus.Z_in                 = 1'b0;
    bus.MAR_in               = 1'b0;
    bus.MDR_in               = 1'b0;
    bus.IncPC                = 1'b0;
    bus.CON_in               = 1'b0;
    bus.Read                 = 1'b0;
    bus.Gra                  = 1'b0;
    bus.Grb                  = 1'b0;
    bus.Grc                  = 1'b0;
    bus.Rin                  = 1'b0;
    bus.Rout                 = 1'b0;
    bus.RX_in_man            = '0;
    bus.alu_instruction_bits = '0;
    bus.run                  = (state != S_RST) && (state != S_HALT);

    case (state)
      S_T0: begin
        bus.PC_out = 1'b1;
        bus.MAR_in = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Z_in   = 1'b1;
      end
      S_T1: begin
        bus.Zlow_out = 1'b1;
        bus.PC_in    = 1'b1;
        bus.Read     = 1'b1;
        bus.MDR_in   = 1'b1;
      end
      S_T2: begin
        bus.MDR_out = 1'b1;
        bus.IR_in   = 1'b1;
      end
      S_T3: begin
        if (is_rtype(op_live)) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Y_in = 1'b1;
        end else if (op_live == OP_JR) begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.PC_in = 1'b1;
        end else if (op_live == OP_JAL) begin
          bus.PC_out    = 1'b1;
          bus.RX_in_man = 16'h8000;
        end else if (op_live == OP_BR) begin
          bus.Gra    = 1'b1;
          bus.Rout   = 1'b1;
          bus.CON_in = 1'b1;
        end
      end
      S_T4: begin
        if (is_rtype(op_q)) begin
          bus.Grc                  = 1'b1;
          bus.Rout                 = 1'b1;
          bus.Z_in                 = 1'b1;
          bus.alu_instruction_bits = op_q;
        end else if (op_q == OP_JAL) begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.PC_in = 1'b1;
        end else if (op_q == OP_BR) begin
          bus.PC_out = 1'b1;
          bus.Y_in   = 1'b1;
        end
      end
      S_T5: begin
        if (is_rtype(op_q)) begin
          bus.Zlow_out = 1'b1;
          bus.Gra      = 1'b1;
          bus.Rin      = 1'b1;
        end else if (op_q == OP_BR) begin
          bus.C_out                = 1'b1;
          bus.Z_in                 = 1'b1;
          bus.alu_instruction_bits = ALU_ADD;
        end
      end
      S_T6: begin
        // Branch commit: Z holds PC+C, loaded only when the condition held.
        bus.Zlow_out = 1'b1;
        bus.PC_in    = bus.CON_out;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: control-word vectors over a small program, plus
// hand sequences for jr, jal, branch not taken, halt and mid-instruction clear.
module tb_ctrl_sequencer;
  logic clk;
  logic clr;
  logic con;

  ctrl_sequencer_if bus ();
  ctrl_sequencer dut (.clk(clk), .clr(clr), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word bit map
  localparam logic [40:0] RUN   = 41'(1) << 40;
  localparam logic [40:0] PCO   = 41'(1) << 39;
  localparam logic [40:0] ZLO   = 41'(1) << 37;
  localparam logic [40:0] MDRO  = 41'(1) << 36;
  localparam logic [40:0] COUT  = 41'(1) << 35;
  localparam logic [40:0] PCI   = 41'(1) << 34;
  localparam logic [40:0] IRI   = 41'(1) << 33;
  localparam logic [40:0] YI    = 41'(1) << 32;
  localparam logic [40:0] ZI    = 41'(1) << 31;
  localparam logic [40:0] MARI  = 41'(1) << 30;
  localparam logic [40:0] MDRI  = 41'(1) << 29;
  localparam logic [40:0] INC   = 41'(1) << 28;
  localparam logic [40:0] CONI  = 41'(1) << 27;
  localparam logic [40:0] RD    = 41'(1) << 26;
  localparam logic [40:0] GRA   = 41'(1) << 25;
  localparam logic [40:0] GRB   = 41'(1) << 24;
  localparam logic [40:0] GRC   = 41'(1) << 23;
  localparam logic [40:0] RIN   = 41'(1) << 22;
  localparam logic [40:0] ROUT  = 41'(1) << 21;
  localparam logic [40:0] RX15  = 41'(1) << 20;

  localparam logic [40:0] W_T0  = RUN | PCO | MARI | INC | ZI;
  localparam logic [40:0] W_T1  = RUN | ZLO | PCI | RD | MDRI;
  localparam logic [40:0] W_T2  = RUN | MDRO | IRI;
  localparam logic [40:0] W_R3  = RUN | GRB | ROUT | YI;
  localparam logic [40:0] W_R5  = RUN | ZLO | GRA | RIN;
  localparam logic [40:0] W_B3  = RUN | GRA | ROUT | CONI;
  localparam logic [40:0] W_B4  = RUN | PCO | YI;
  localparam logic [40:0] W_B5  = RUN | COUT | ZI | 41'(3);
  localparam logic [40:0] W_JR3 = RUN | GRA | ROUT | PCI;
  localparam logic [40:0] W_JL3 = RUN | PCO | RX15;

  localparam logic [31:0] I_ADD  = 32'h18920000; // add R1,R2,R4
  localparam logic [31:0] I_SUB  = 32'h22A10000; // sub R5,R4,R2
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_BAD  = 32'h00000000;
  localparam logic [31:0] I_BR5  = 32'h98000005; // branch, C = 5
  localparam logic [31:0] I_JR2  = 32'hA1000000;
  localparam logic [31:0] I_JAL3 = 32'hA9800000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  logic [40:0] cw;
  assign cw = {bus.run, bus.PC_out, bus.Zhigh_out, bus.Zlow_out, bus.MDR_out, bus.C_out,
               bus.PC_in, bus.IR_in, bus.Y_in, bus.Z_in, bus.MAR_in, bus.MDR_in, bus.IncPC,
               bus.CON_in, bus.Read, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
               bus.RX_in_man, bus.alu_instruction_bits};

  // Reference datapath that consumes the control word each cycle
  logic [31:0] r [16];
  logic [31:0] mem [256];
  logic [31:0] pc, mar, mdr, ir, y, z;

  assign bus.IR_Data = ir;
  assign bus.CON_out = con;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        c;
    logic [40:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd3:    return a + b;
      5'd4:    return a - b;
      5'd5:    return a & b;
      5'd6:    return a | b;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] b;
    logic [31:0] c_ext;
    logic [3:0]  sel;
    c_ext = {{13{ir[18]}}, ir[18:0]};
    sel   = bus.Gra ? ir[26:23] : (bus.Grb ? ir[22:19] : ir[18:15]);
    b     = '0;
    if (bus.PC_out)        b = pc;
    else if (bus.Zlow_out) b = z;
    else if (bus.MDR_out)  b = mdr;
    else if (bus.C_out)    b = c_ext;
    else if (bus.Rout)     b = r[sel];
    if (bus.IR_in) ir = mdr;
    if (bus.MDR_in && bus.Read) mdr = mem[mar[7:0]];
    if (bus.Z_in) z = bus.IncPC ? b + 32'd1 : alu(bus.alu_instruction_bits, y, b);
    if (bus.MAR_in) mar = b;
    if (bus.Y_in) y = b;
    if (bus.PC_in) pc = b;
    if (bus.Rin) r[sel] = b;
    if (bus.RX_in_man[15]) r[15] = b;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_cw(input string name, input logic [40:0] exp);
    chk(name, cw, exp);
    step();
  endtask

  // Pulse clr at a negedge; returns at the negedge where the first T0 should be showing.
  task automatic do_reset();
    clr = 1'b1;
    #1 chk("reset_outputs", cw, '0);
    @(negedge clk);
    chk("reset_held", cw, '0);
    clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    con = 1'b0;
    pc = '0; mar = '0; mdr = '0; ir = '0; y = '0; z = '0;
    for (int i = 0; i < 16; i++) r[i] = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);

    // Program: add, nop, unsupported, branch taken to 9, sub
    tbl.push_back('{1'b0, W_T0}); tbl.push_back('{1'b0, W_T1}); tbl.push_back('{1'b0, W_T2});
    tbl.push_back('{1'b0, W_R3}); tbl.push_back('{1'b0, RUN | GRC | ROUT | ZI | 41'(3)});
    tbl.push_back('{1'b0, W_R5});
    tbl.push_back('{1'b0, W_T0}); tbl.push_back('{1'b0, W_T1}); tbl.push_back('{1'b0, W_T2});
    tbl.push_back('{1'b0, RUN});
    tbl.push_back('{1'b0, W_T0}); tbl.push_back('{1'b0, W_T1}); tbl.push_back('{1'b0, W_T2});
    tbl.push_back('{1'b0, RUN});
    tbl.push_back('{1'b1, W_T0}); tbl.push_back('{1'b1, W_T1}); tbl.push_back('{1'b1, W_T2});
    tbl.push_back('{1'b1, W_B3}); tbl.push_back('{1'b1, W_B4}); tbl.push_back('{1'b1, W_B5});
    tbl.push_back('{1'b1, RUN | ZLO | PCI});
    tbl.push_back('{1'b0, W_T0}); tbl.push_back('{1'b0, W_T1}); tbl.push_back('{1'b0, W_T2});
    tbl.push_back('{1'b0, W_R3}); tbl.push_back('{1'b0, RUN | GRC | ROUT | ZI | 41'(4)});
    tbl.push_back('{1'b0, W_R5});

    do_reset();
    mem[0] = I_ADD; mem[1] = I_NOP; mem[2] = I_BAD; mem[3] = I_BR5; mem[9] = I_SUB;
    r[2] = 32'd5; r[4] = 32'd7; pc = '0;
    foreach (tbl[i]) begin
      con = tbl[i].c;
      chk($sformatf("vec%0d", i), cw, tbl[i].exp);
      step();
    end
    chk("add_r1", 41'(r[1]), 41'(32'd12));
    chk("sub_r5", 41'(r[5]), 41'(32'd2));
    chk("br_taken_pc", 41'(pc), 41'(32'd10));
    chk("prog_next_t0", cw, W_T0);

    // jr R2 from PC 0
    do_reset();
    pc = '0; mem[0] = I_JR2; r[2] = 32'h000000FF;
    expect_cw("jr_t0", W_T0); expect_cw("jr_t1", W_T1); expect_cw("jr_t2", W_T2);
    expect_cw("jr_t3", W_JR3);
    chk("jr_pc", 41'(pc), 41'(32'hFF));
    chk("jr_next_t0", cw, W_T0);

    // jal R3 from PC 0x10
    do_reset();
    pc = 32'h10; mem[8'h10] = I_JAL3; r[3] = 32'h40; r[15] = '0;
    expect_cw("jal_t0", W_T0); expect_cw("jal_t1", W_T1); expect_cw("jal_t2", W_T2);
    expect_cw("jal_t3", W_JL3);
    chk("jal_r15", 41'(r[15]), 41'(32'h11));
    expect_cw("jal_t4", W_JR3);
    chk("jal_pc", 41'(pc), 41'(32'h40));
    chk("jal_next_t0", cw, W_T0);

    // Branch not taken
    do_reset();
    pc = 32'h20; mem[8'h20] = I_BR5; con = 1'b0;
    expect_cw("bnt_t0", W_T0); expect_cw("bnt_t1", W_T1); expect_cw("bnt_t2", W_T2);
    expect_cw("bnt_t3", W_B3); expect_cw("bnt_t4", W_B4); expect_cw("bnt_t5", W_B5);
    expect_cw("bnt_t6", RUN | ZLO);
    chk("bnt_pc", 41'(pc), 41'(32'h21));
    chk("bnt_next_t0", cw, W_T0);

    // Halt, hold, then clr resumes fetch
    do_reset();
    pc = '0; mem[0] = I_HALT;
    expect_cw("halt_t0", W_T0); expect_cw("halt_t1", W_T1); expect_cw("halt_t2", W_T2);
    expect_cw("halt_t3", RUN);
    for (int k = 0; k < 10; k++) expect_cw($sformatf("halt_hold%0d", k), '0);
    #2 clr = 1'b1;
    #1 chk("halt_clr", cw, '0);
    @(negedge clk);
    clr = 1'b0;
    pc = '0; mem[0] = I_NOP;
    @(negedge clk);
    chk("halt_resume_t0", cw, W_T0);

    // Asynchronous clear during T4 of add
    do_reset();
    pc = '0; mem[0] = I_ADD; r[1] = '0; r[2] = 32'd5; r[4] = 32'd7;
    expect_cw("mid_t0", W_T0); expect_cw("mid_t1", W_T1); expect_cw("mid_t2", W_T2);
    expect_cw("mid_t3", W_R3);
    chk("mid_t4", cw, RUN | GRC | ROUT | ZI | 41'(3));
    #2 clr = 1'b1;
    #1 chk("mid_clr_async", cw, '0);
    @(negedge clk);
    step();
    step();
    chk("mid_clr_held", cw, '0);
    chk("mid_r1_kept", 41'(r[1]), 41'(32'd0));
    clr = 1'b0;
    @(negedge clk);
    chk("mid_resume_t0", cw, W_T0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
